// File: rtl/wb_queue.sv
// Pending register-write queue that sits in front of the register-file write port.
// Writes are accepted from the producer and drained in order whenever the write port
// is free. Two combinational bypass ports let decode read the youngest pending value
// of a register before it reaches the register file.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata,
    input  logic [4:0]               rd_addr1,
    input  logic [4:0]               rd_addr2,
    output logic                     byp_hit1,
    output logic                     byp_hit2,
    output logic [DATA_W-1:0]        byp_data1,
    output logic [DATA_W-1:0]        byp_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry payload; validity is implied by the head/count window, so no reset needed.
    logic [4:0]        r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_idx;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    // Ready is based on occupancy only, never on a same-cycle drain.
    assign in_ready = ~full;
    assign rf_we    = drain_en & ~empty;
    assign w_pop    = rf_we;
    // Writes to register 0 complete the handshake but are dropped.
    assign w_push   = in_valid & in_ready & (in_reg != 5'd0);
    assign rf_waddr = empty ? 5'd0 : r_reg[r_head];
    assign rf_wdata = empty ? '0 : r_data[r_head];

    // Pointer and occupancy state; asynchronously cleared so pending writes vanish at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload write at the tail slot on an accepted non-zero-register push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_reg[r_tail]  <= in_reg;
            r_data[r_tail] <= in_data;
        end
    end

    // Bypass lookup: scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = '0;
        byp_data2 = '0;
        w_idx     = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if ((rd_addr1 != 5'd0) && (r_reg[w_idx] == rd_addr1)) begin
                    byp_hit1  = 1'b1;
                    byp_data1 = r_data[w_idx];
                end
                if ((rd_addr2 != 5'd0) && (r_reg[w_idx] == rd_addr2)) begin
                    byp_hit2  = 1'b1;
                    byp_data2 = r_data[w_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed scenario tasks plus a negedge scoreboard monitor that
// predicts occupancy, drain order and bypass results from a simple in-order queue.
module tb_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [4:0]        r;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_reg;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [4:0]        rd_addr1;
    logic [4:0]        rd_addr2;
    logic              byp_hit1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data1;
    logic [DATA_W-1:0] byp_data2;
    logic [2:0]        count;
    logic              empty;
    logic              full;

    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    ent_t sb[$];

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compare against the model before the coming edge, then update it.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            logic              exp_we;
            logic              eh1, eh2;
            logic [DATA_W-1:0] ed1, ed2;
            exp_we = drain_en && (sb.size() > 0);
            n_cmp++;
            if (int'(count) != sb.size()) begin
                n_fail++;
                $display("FAIL mon_count: got %0d expected %0d", count, sb.size());
            end
            n_cmp++;
            if (rf_we !== exp_we) begin
                n_fail++;
                $display("FAIL mon_rf_we: got %b expected %b", rf_we, exp_we);
            end
            if (exp_we) begin
                n_cmp++;
                if (rf_waddr !== sb[0].r || rf_wdata !== sb[0].d) begin
                    n_fail++;
                    $display("FAIL mon_drain: got %0d/%0h expected %0d/%0h",
                             rf_waddr, rf_wdata, sb[0].r, sb[0].d);
                end
            end
            eh1 = 1'b0; eh2 = 1'b0; ed1 = '0; ed2 = '0;
            foreach (sb[k]) begin
                if (rd_addr1 != 0 && sb[k].r == rd_addr1) begin eh1 = 1'b1; ed1 = sb[k].d; end
                if (rd_addr2 != 0 && sb[k].r == rd_addr2) begin eh2 = 1'b1; ed2 = sb[k].d; end
            end
            n_cmp++;
            if (byp_hit1 !== eh1 || byp_data1 !== ed1 || byp_hit2 !== eh2 || byp_data2 !== ed2) begin
                n_fail++;
                $display("FAIL mon_bypass: got %b/%0h %b/%0h expected %b/%0h %b/%0h",
                         byp_hit1, byp_data1, byp_hit2, byp_data2, eh1, ed1, eh2, ed2);
            end
            if (exp_we) void'(sb.pop_front());
            if (in_valid && in_ready && in_reg != 5'd0) sb.push_back('{r: in_reg, d: in_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drain_en = 1'b1;
        rd_addr1 = 5'd1;
        #2;
        n_cmp++;
        if (in_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy=%b e=%b f=%b c=%0d expected 1 1 0 0",
                     in_ready, empty, full, count);
        end
        n_cmp++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rf: got %b/%0d/%0h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++;
        if (byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0 || byp_data1 !== '0 || byp_data2 !== '0) begin
            n_fail++;
            $display("FAIL reset_byp: got %b %b %0h %0h expected 0 0 0 0",
                     byp_hit1, byp_hit2, byp_data1, byp_data2);
        end
        step();
        reset    = 1'b0;
        drain_en = 1'b0;
        rd_addr1 = 5'd0;
        mon_en   = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: got rdy=%b e=%b expected 1 1", in_ready, empty);
        end
    endtask

    task automatic test_fill_drain();
        drain_en = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            in_valid = 1'b1;
            in_reg   = 5'(n);
            in_data  = 32'(n * 'h11);
            step();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL fill: got f=%b rdy=%b c=%0d expected 1 0 4", full, in_ready, count);
        end
        drain_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            n_cmp++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'(k * 'h11)) begin
                n_fail++;
                $display("FAIL drain_%0d: got %b/%0d/%0h expected 1/%0d/%0h",
                         k, rf_we, rf_waddr, rf_wdata, k, k * 'h11);
            end
            step();
        end
        #1;
        n_cmp++;
        if (empty !== 1'b1 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: got e=%b we=%b expected 1 0", empty, rf_we);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_bypass();
        drain_en = 1'b0;
        in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hA; step();
        in_data  = 32'hB; step();
        in_valid = 1'b0;
        rd_addr1 = 5'd5;
        rd_addr2 = 5'd6;
        #1;
        n_cmp++;
        if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hB || byp_hit2 !== 1'b0 || byp_data2 !== '0) begin
            n_fail++;
            $display("FAIL byp_youngest: got %b/%0h %b/%0h expected 1/b 0/0",
                     byp_hit1, byp_data1, byp_hit2, byp_data2);
        end
        drain_en = 1'b1; step(); drain_en = 1'b0;
        #1;
        n_cmp++;
        if (byp_hit1 !== 1'b1 || byp_data1 !== 32'hB) begin
            n_fail++;
            $display("FAIL byp_after_pop: got %b/%0h expected 1/b", byp_hit1, byp_data1);
        end
        drain_en = 1'b1; step(); drain_en = 1'b0;
        #1;
        n_cmp++;
        if (byp_hit1 !== 1'b0 || byp_data1 !== '0) begin
            n_fail++;
            $display("FAIL byp_gone: got %b/%0h expected 0/0", byp_hit1, byp_data1);
        end
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
    endtask

    task automatic test_zero_reg();
        drain_en = 1'b1;
        in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hDEAD;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd0 || rf_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dropped: got c=%0d we=%b expected 0 0", count, rf_we);
        end
        drain_en = 1'b0;
        in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h1; step();
        in_valid = 1'b0;
        rd_addr1 = 5'd0;
        #1;
        n_cmp++;
        if (byp_hit1 !== 1'b0 || byp_data1 !== '0) begin
            n_fail++;
            $display("FAIL zero_no_hit: got %b/%0h expected 0/0", byp_hit1, byp_data1);
        end
        drain_en = 1'b1; step(); drain_en = 1'b0;
    endtask

    task automatic test_full_push_pop();
        int g;
        drain_en = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            in_valid = 1'b1; in_reg = 5'(n); in_data = 32'('h100 + n);
            step();
        end
        in_reg = 5'd9; in_data = 32'h99; drain_en = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || rf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_ready: got rdy=%b we=%b expected 0 1", in_ready, rf_we);
        end
        step();
        #1;
        n_cmp++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_pop: got c=%0d rdy=%b expected 3 1", count, in_ready);
        end
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (count !== 3'd3) begin
            n_fail++;
            $display("FAIL push_with_pop: got c=%0d expected 3", count);
        end
        g = 0;
        while (!empty && g < 20) begin step(); g++; end
        n_cmp++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain_timeout: got e=%b expected 1", empty);
        end
        drain_en = 1'b0;
    endtask

    task automatic test_wrap();
        int n, got, guard;
        n = 1; got = 0; guard = 0;
        drain_en = 1'b1;
        while (got < 10 && guard < 200) begin
            if (n <= 10) begin
                in_valid = 1'($urandom_range(0, 1));
                in_reg   = 5'(n);
                in_data  = 32'(n);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (rf_we) begin
                n_cmp++;
                if (rf_waddr !== 5'(got + 1) || rf_wdata !== 32'(got + 1)) begin
                    n_fail++;
                    $display("FAIL wrap_order: got %0d/%0h expected %0d/%0h",
                             rf_waddr, rf_wdata, got + 1, got + 1);
                end
                got++;
            end
            n_cmp++;
            if (count > 3'd4) begin
                n_fail++;
                $display("FAIL wrap_count: got %0d expected <=4", count);
            end
            if (in_valid && in_ready) n++;
            step();
            guard++;
        end
        in_valid = 1'b0;
        drain_en = 1'b0;
        n_cmp++;
        if (got != 10) begin
            n_fail++;
            $display("FAIL wrap_total: got %0d expected 10", got);
        end
    endtask

    task automatic test_async_reset();
        drain_en = 1'b0;
        for (int n = 11; n <= 13; n++) begin
            in_valid = 1'b1; in_reg = 5'(n); in_data = 32'(n);
            step();
        end
        in_valid = 1'b0;
        rd_addr1 = 5'd12;
        #2;
        reset    = 1'b1;
        sb.delete();
        drain_en = 1'b1;
        #1;
        n_cmp++;
        if (count !== 3'd0 || empty !== 1'b1 || rf_we !== 1'b0 || byp_hit1 !== 1'b0 || byp_hit2 !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got c=%0d e=%b we=%b h=%b%b expected 0 1 0 00",
                     count, empty, rf_we, byp_hit1, byp_hit2);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (rf_we !== 1'b0 || empty !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_write_%0d: got we=%b e=%b expected 0 1", k, rf_we, empty);
            end
            step();
        end
        drain_en = 1'b0;
        rd_addr1 = 5'd0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_reg   = 5'd0;
        in_data  = '0;
        drain_en = 1'b0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        test_reset();
        test_fill_drain();
        test_bypass();
        test_zero_reg();
        test_full_push_pop();
        test_wrap();
        test_async_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
